// File: rtl/frame_serializer_ctrl_pkg.sv
// frame_serializer_ctrl_pkg
//   Shared types and helpers for the frame serializer.
//   - state_t : serializer sequencing states (IDLE/LOAD/SHIFT/GAP), 2-bit encoding
//   - DEF_*   : default parameter values
//   - cnt_w() : width of a down/up counter that must hold 0..n-1 (minimum 1 bit)
package frame_serializer_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   localparam int DEF_DATA_W          = 16;
   localparam int DEF_WORDS_PER_FRAME = 8;
   localparam int DEF_GAP_BITS        = 2;

   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/frame_serializer_ctrl_if.sv
// frame_serializer_ctrl_if
//   Bundles the bit-slot tick, run permission, upstream valid/ready word port
//   and the serial output side of the frame serializer.
//   slave  : serializer side (consumes words, drives serial outputs)
//   master : driver side (supplies ena/is_running/words, observes outputs)
interface frame_serializer_ctrl_if #(
   parameter int DATA_W          = 16,
   parameter int WORDS_PER_FRAME = 8
);
   localparam int WC_W = $clog2(WORDS_PER_FRAME + 1);

   logic              ena;
   logic              is_running;
   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;
   logic              ser_out;
   logic              ser_valid;
   logic              frame_start;
   logic              frame_end;
   logic              underrun;
   logic [WC_W-1:0]   word_cnt;

   modport slave (
      input  ena, is_running, s_data, s_valid,
      output s_ready, ser_out, ser_valid, frame_start, frame_end, underrun, word_cnt
   );

   modport master (
      output ena, is_running, s_data, s_valid,
      input  s_ready, ser_out, ser_valid, frame_start, frame_end, underrun, word_cnt
   );

endinterface

// File: rtl/frame_serializer_ctrl_shreg.sv
// frame_serializer_ctrl_shreg
//   DATA_W-bit load/shift register, MSB first.
//   clk     : clock
//   rst     : synchronous active-high reset (clears register)
//   i_load  : capture i_data (takes priority over shift)
//   i_shift : shift left by one, zero fill
//   i_data  : parallel word
//   o_msb   : current MSB
module frame_serializer_ctrl_shreg #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic              i_shift,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_msb
);

   logic [DATA_W-1:0] r_shreg;
   logic [DATA_W-1:0] w_shifted;

   assign w_shifted[0] = 1'b0;
   for (genvar gi = 1; gi < DATA_W; gi++) begin : g_shift
      assign w_shifted[gi] = r_shreg[gi-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shreg <= '0;
      end else if (i_load) begin
         r_shreg <= i_data;
      end else if (i_shift) begin
         r_shreg <= w_shifted;
      end
   end

   assign o_msb = r_shreg[DATA_W-1];

endmodule

// File: rtl/frame_serializer_ctrl.sv
// frame_serializer_ctrl
//   Pulls words over a valid/ready handshake while running, shifts each out
//   MSB first one bit per ena slot, groups WORDS_PER_FRAME words into a frame
//   followed by GAP_BITS idle slots, and flags a sticky underrun when the
//   upstream stalls mid-frame.
//   clk  : clock, everything on posedge
//   rst  : synchronous active-high reset
//   bus  : frame_serializer_ctrl_if.slave
//          in : ena, is_running, s_data, s_valid
//          out: s_ready (combinational), ser_out, ser_valid, frame_start,
//               frame_end, underrun (sticky), word_cnt
module frame_serializer_ctrl
   import frame_serializer_ctrl_pkg::*;
#(
   parameter int DATA_W          = DEF_DATA_W,
   parameter int WORDS_PER_FRAME = DEF_WORDS_PER_FRAME,
   parameter int GAP_BITS        = DEF_GAP_BITS
) (
   input logic                  clk,
   input logic                  rst,
   frame_serializer_ctrl_if.slave bus
);

   localparam int WC_W = $clog2(WORDS_PER_FRAME + 1);
   localparam int BC_W = cnt_w(DATA_W);
   localparam int GC_W = cnt_w(GAP_BITS);

   localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS_PER_FRAME - 1);
   localparam logic [BC_W-1:0] TOP_BIT   = BC_W'(DATA_W - 1);
   localparam logic [GC_W-1:0] GAP_TOP   = GC_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

   state_t          r_state;
   logic [BC_W-1:0] r_bit_cnt;
   logic [WC_W-1:0] r_word_cnt;
   logic [GC_W-1:0] r_gap_cnt;
   logic            r_ser_out;
   logic            r_ser_valid;
   logic            r_frame_start;
   logic            r_frame_end;
   logic            r_underrun;

   logic            w_load;
   logic            w_shift;
   logic            w_msb;

   // The load strobe is exactly the handshake cycle.
   assign w_load  = bus.ena && (r_state == ST_LOAD) && bus.s_valid && !rst;
   assign w_shift = bus.ena && (r_state == ST_SHIFT) && !rst;

   frame_serializer_ctrl_shreg #(.DATA_W(DATA_W)) u_shreg (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_data  (bus.s_data),
      .o_msb   (w_msb)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_bit_cnt     <= '0;
         r_word_cnt    <= '0;
         r_gap_cnt     <= '0;
         r_ser_out     <= 1'b0;
         r_ser_valid   <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_end   <= 1'b0;
         r_underrun    <= 1'b0;
      end else if (bus.ena) begin
         // Every slot that is not a SHIFT slot presents an idle serial line.
         r_ser_out     <= 1'b0;
         r_ser_valid   <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_end   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.is_running) begin
                  r_state    <= ST_LOAD;
                  r_word_cnt <= '0;
               end
            end
            ST_LOAD: begin
               if (bus.s_valid) begin
                  r_bit_cnt <= TOP_BIT;
                  r_state   <= ST_SHIFT;
               end else if (r_word_cnt == '0) begin
                  // Frame boundary: the only place run permission is honoured.
                  if (!bus.is_running) begin
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_underrun <= 1'b1;
               end
            end
            ST_SHIFT: begin
               r_ser_out     <= w_msb;
               r_ser_valid   <= 1'b1;
               r_frame_start <= (r_word_cnt == '0) && (r_bit_cnt == TOP_BIT);
               r_frame_end   <= (r_word_cnt == LAST_WORD) && (r_bit_cnt == '0);
               r_bit_cnt     <= r_bit_cnt - BC_W'(1);
               if (r_bit_cnt == '0) begin
                  if (r_word_cnt == LAST_WORD) begin
                     r_word_cnt <= '0;
                     if (GAP_BITS == 0) begin
                        r_state <= ST_LOAD;
                     end else begin
                        r_state   <= ST_GAP;
                        r_gap_cnt <= GAP_TOP;
                     end
                  end else begin
                     r_word_cnt <= r_word_cnt + WC_W'(1);
                     r_state    <= ST_LOAD;
                  end
               end
            end
            ST_GAP: begin
               if (r_gap_cnt == '0) begin
                  r_state <= bus.is_running ? ST_LOAD : ST_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt - GC_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.s_ready     = (r_state == ST_LOAD) && bus.ena && !rst;
   assign bus.ser_out     = r_ser_out;
   assign bus.ser_valid   = r_ser_valid;
   assign bus.frame_start = r_frame_start;
   assign bus.frame_end   = r_frame_end;
   assign bus.underrun    = r_underrun;
   assign bus.word_cnt    = r_word_cnt;

endmodule

// File: tb/tb_frame_serializer_ctrl.sv
// tb_frame_serializer_ctrl
//   Self-checking bench for frame_serializer_ctrl (DATA_W=16, WORDS_PER_FRAME=2,
//   GAP_BITS=2): directed frame table, a mid-shift reset sequence, and a
//   randomized run compared against a queue-based reference model.
module tb_frame_serializer_ctrl;

   localparam int DW  = 16;
   localparam int WPF = 2;
   localparam int GAP = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   frame_serializer_ctrl_if #(.DATA_W(DW), .WORDS_PER_FRAME(WPF)) bus ();

   frame_serializer_ctrl #(
      .DATA_W          (DW),
      .WORDS_PER_FRAME (WPF),
      .GAP_BITS        (GAP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [6:0] dut_outs;
   assign dut_outs = {bus.ser_out, bus.ser_valid, bus.frame_start, bus.frame_end,
                      bus.underrun, bus.word_cnt};

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model: queue of scheduled output slots -------------
   typedef struct {
      logic b;
      logic v;
      logic fs;
      logic fe;
      logic last_bit;
      logic gap_last;
      int   wc_next;
   } ent_t;

   ent_t m_q[$];
   logic m_idle, m_so, m_sv, m_fs, m_fe, m_und;
   int   m_wc;

   task automatic m_reset();
      m_q.delete();
      m_idle = 1'b1;
      m_so = 1'b0; m_sv = 1'b0; m_fs = 1'b0; m_fe = 1'b0; m_und = 1'b0;
      m_wc = 0;
   endtask

   task automatic model_step(input logic r, input logic e, input logic run,
                             input logic val, input logic [DW-1:0] d);
      ent_t x;
      if (r) begin
         m_reset();
         return;
      end
      if (!e) return;
      m_so = 1'b0; m_sv = 1'b0; m_fs = 1'b0; m_fe = 1'b0;
      if (m_q.size() > 0) begin
         x = m_q.pop_front();
         m_so = x.b; m_sv = x.v; m_fs = x.fs; m_fe = x.fe;
         if (x.last_bit) m_wc = x.wc_next;
         if (x.gap_last && !run) m_idle = 1'b1;
      end else if (m_idle) begin
         if (run) m_idle = 1'b0;
      end else if (val) begin
         for (int i = 0; i < DW; i++) begin
            x.b        = d[DW-1-i];
            x.v        = 1'b1;
            x.fs       = (m_wc == 0) && (i == 0);
            x.fe       = (m_wc == WPF-1) && (i == DW-1);
            x.last_bit = (i == DW-1);
            x.gap_last = 1'b0;
            x.wc_next  = (m_wc + 1) % WPF;
            m_q.push_back(x);
         end
         if (m_wc == WPF-1) begin
            for (int g = 0; g < GAP; g++) begin
               x.b = 1'b0; x.v = 1'b0; x.fs = 1'b0; x.fe = 1'b0; x.last_bit = 1'b0;
               x.gap_last = (g == GAP-1);
               x.wc_next  = 0;
               m_q.push_back(x);
            end
         end
      end else if (m_wc == 0) begin
         if (!run) m_idle = 1'b1;
      end else begin
         m_und = 1'b1;
      end
   endtask

   // ---------------- reset with busy inputs -------------
   task automatic do_reset(input int n);
      rst = 1'b1;
      bus.ena = 1'b1; bus.is_running = 1'b1; bus.s_valid = 1'b1;
      bus.s_data = 16'($urandom);
      for (int i = 0; i < n; i++) begin
         #1;
         chk("rst_s_ready", bus.s_ready, 1'b0);
         step();
      end
      rst = 1'b0;
      bus.ena = 1'b0; bus.is_running = 1'b0; bus.s_valid = 1'b0;
      chk("rst_outs", dut_outs, 7'd0);
      m_reset();
   endtask

   // ---------------- directed frame table -------------
   typedef struct {
      int              ena_div;
      logic [DW-1:0]   w0;
      logic [DW-1:0]   w1;
      int              stall;      // LOAD slots without data before word 1
      logic [2*DW-1:0] exp_bits;
      int              exp_span;   // ena slots from first to last data bit
      logic            exp_und;
   } vec_t;

   vec_t vecs[4];

   task automatic run_row(input vec_t v, input int r);
      int hs = 0, stall_left = v.stall, slot = 0, nbits = 0;
      int first = -1, last = -1, fs_cnt = 0, fe_cnt = 0, fs_slot = -1, fe_slot = -1;
      int rdy_bad = 0, chg_bad = 0, post_bad = 0;
      logic [2*DW-1:0] bits = '0;
      logic end_seen = 1'b0, ena_d;
      logic [6:0] prev;
      do_reset(3);
      for (int c = 0; c < 240; c++) begin
         bus.ena        = (c % v.ena_div) == 0;
         bus.is_running = (hs == 0);
         bus.s_data     = (hs == 0) ? v.w0 : v.w1;
         bus.s_valid    = (hs < 2) && !(hs == 1 && stall_left > 0);
         prev  = dut_outs;
         ena_d = bus.ena;
         #1;
         if (bus.s_ready && !bus.ena) rdy_bad++;
         if (bus.s_ready && end_seen) post_bad++;
         if (bus.ena && bus.s_ready) begin
            if (bus.s_valid) hs++;
            else if (hs == 1) stall_left--;
         end
         step();
         if (!ena_d) begin
            if (dut_outs !== prev) chg_bad++;
         end else begin
            if (bus.ser_valid) begin
               bits = {bits[2*DW-2:0], bus.ser_out};
               nbits++;
               if (first < 0) first = slot;
               last = slot;
               if (end_seen) post_bad++;
            end
            if (bus.frame_start) begin fs_cnt++; fs_slot = slot; end
            if (bus.frame_end) begin fe_cnt++; fe_slot = slot; end_seen = 1'b1; end
            slot++;
         end
      end
      $display("row %0d: ena_div=%0d words=%h/%h stall=%0d bits=%h underrun=%0d",
               r, v.ena_div, v.w0, v.w1, v.stall, bits, bus.underrun);
      chk($sformatf("r%0d bits", r), bits, v.exp_bits);
      chk($sformatf("r%0d nbits", r), nbits, 2*DW);
      chk($sformatf("r%0d first_slot", r), first, 2);
      chk($sformatf("r%0d last_slot", r), last, 2 + v.exp_span - 1);
      chk($sformatf("r%0d fs_cnt", r), fs_cnt, 1);
      chk($sformatf("r%0d fs_slot", r), fs_slot, 2);
      chk($sformatf("r%0d fe_cnt", r), fe_cnt, 1);
      chk($sformatf("r%0d fe_slot", r), fe_slot, 2 + v.exp_span - 1);
      chk($sformatf("r%0d underrun", r), bus.underrun, v.exp_und);
      chk($sformatf("r%0d rdy_without_ena", r), rdy_bad, 0);
      chk($sformatf("r%0d change_without_ena", r), chg_bad, 0);
      chk($sformatf("r%0d activity_after_frame", r), post_bad, 0);
      chk($sformatf("r%0d handshakes", r), hs, 2);
      chk($sformatf("r%0d word_cnt_end", r), bus.word_cnt, 2'd0);
   endtask

   logic run_state;
   logic exp_rdy;

   initial begin
      rst = 1'b1;
      bus.ena = 1'b0; bus.is_running = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
      vecs[0] = '{1, 16'hA5C3, 16'h0F0F, 0, 32'hA5C30F0F, 33, 1'b0};
      vecs[1] = '{3, 16'hA5C3, 16'h0F0F, 0, 32'hA5C30F0F, 33, 1'b0};
      vecs[2] = '{1, 16'hA5C3, 16'h0F0F, 5, 32'hA5C30F0F, 38, 1'b1};
      vecs[3] = '{2, 16'hFFFF, 16'h8001, 3, 32'hFFFF8001, 36, 1'b1};
      step();

      // reset state
      do_reset(3);
      $display("reset: outs=%h s_ready=%0d", dut_outs, bus.s_ready);

      // frame table
      for (int r = 0; r < 4; r++) run_row(vecs[r], r);

      // reset in the middle of a word, then a clean restart
      do_reset(2);
      bus.ena = 1'b1; bus.is_running = 1'b1; bus.s_valid = 1'b1; bus.s_data = 16'hFFFF;
      repeat (10) step();
      chk("t6 mid_word", {bus.ser_valid, bus.ser_out}, 2'b11);
      rst = 1'b1;
      #1;
      chk("t6 s_ready_in_rst", bus.s_ready, 1'b0);
      step();
      chk("t6 outs_after_rst", dut_outs, 7'd0);
      rst = 1'b0;
      bus.s_data = 16'h8001;
      #1;
      chk("t6 idle_s_ready", bus.s_ready, 1'b0);
      step();
      #1;
      chk("t6 load_s_ready", bus.s_ready, 1'b1);
      step();
      chk("t6 bubble", bus.ser_valid, 1'b0);
      step();
      chk("t6 first_bit", {bus.ser_valid, bus.ser_out, bus.frame_start, bus.word_cnt}, 5'b11100);
      repeat (15) step();
      chk("t6 last_bit", {bus.ser_valid, bus.ser_out, bus.frame_end, bus.word_cnt}, 5'b11001);
      $display("restart: last bit out=%0d word_cnt=%0d", bus.ser_out, bus.word_cnt);

      // randomized run against the reference model
      do_reset(3);
      run_state = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst            = ($urandom_range(0, 299) == 0);
         bus.ena        = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 59) == 0) run_state = ~run_state;
         bus.is_running = run_state;
         bus.s_valid    = ($urandom_range(0, 7) != 0);
         bus.s_data     = 16'($urandom);
         #1;
         exp_rdy = bus.ena && !rst && !m_idle && (m_q.size() == 0);
         chk($sformatf("rnd%0d s_ready", cyc), bus.s_ready, exp_rdy);
         model_step(rst, bus.ena, bus.is_running, bus.s_valid, bus.s_data);
         step();
         chk($sformatf("rnd%0d outs", cyc), dut_outs,
             {m_so, m_sv, m_fs, m_fe, m_und, 2'(m_wc)});
      end
      rst = 1'b0;
      $display("random: 3000 cycles, model underrun=%0d", m_und);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
